// File: rtl/peasant_pkg.sv
// Shared types and defaults for the sequential Russian-peasant multiplier.
package peasant_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} peasant_state_t;

  localparam int PEASANT_WIDTH = 32;

endpackage

// File: rtl/peasant_step.sv
// One halve/double/accumulate iteration of the peasant multiplication, purely combinational.
module peasant_step #(
  parameter int WIDTH = peasant_pkg::PEASANT_WIDTH
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [2*WIDTH-1:0] b,
  input  logic [2*WIDTH-1:0] acc,
  output logic [WIDTH-1:0]   a_nx,
  output logic [2*WIDTH-1:0] b_nx,
  output logic [2*WIDTH-1:0] acc_nx,
  output logic               last
);

  assign a_nx   = a >> 1;
  assign b_nx   = b << 1;
  // b is already 2*WIDTH wide and only ever holds multiplicand << k, k < WIDTH, so no carry is lost.
  assign acc_nx = acc + (a[0] ? b : '0);
  assign last   = (a_nx == '0);

endmodule

// File: rtl/peasant_mult_seq.sv
// Sequential Russian-peasant multiplier: accept an operand pair, step once per clock, return the product.
module peasant_mult_seq
  import peasant_pkg::*;
#(
  parameter int WIDTH      = PEASANT_WIDTH,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  peasant_state_t state, state_nx;

  logic [WIDTH-1:0]   a, a_nx;
  logic [2*WIDTH-1:0] b, b_nx;
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic [CW-1:0]      cnt;
  logic               last;
  logic               run_exit;

  peasant_step #(.WIDTH(WIDTH)) u_step (
    .a      (a),
    .b      (b),
    .acc    (acc),
    .a_nx   (a_nx),
    .b_nx   (b_nx),
    .acc_nx (acc_nx),
    .last   (last)
  );

  assign run_exit = (EARLY_EXIT && last) || (cnt == CW'(WIDTH - 1));

  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values, avoiding order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: default assignment first so no path leaves state_nx unassigned, which would infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (run_exit) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // in_ready is also gated by rst_n so nothing advertises acceptance while reset is held.
  always_comb begin
    in_ready  = rst_n && (state == IDLE);
    busy      = (state == RUN);
    out_valid = (state == DONE);
  end

  assign product = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a   <= '0;
      b   <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (state == IDLE && in_valid) begin
      a   <= multiplier;
      b   <= {{WIDTH{1'b0}}, multiplicand};
      acc <= '0;
      cnt <= '0;
    end else if (state == RUN) begin
      a   <= a_nx;
      b   <= b_nx;
      acc <= acc_nx;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_peasant_mult_seq.sv
// Self-checking bench: early-exit and fixed-length multipliers driven in lockstep against an arithmetic model.
module tb_peasant_mult_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [W-1:0]  multiplicand = '0;
  logic [W-1:0]  multiplier = '0;

  logic          in_ready_e, out_valid_e, busy_e;
  logic [2*W-1:0] product_e;
  logic          in_ready_f, out_valid_f, busy_f;
  logic [2*W-1:0] product_f;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  peasant_mult_seq #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_e),
    .multiplicand(multiplicand), .multiplier(multiplier), .out_valid(out_valid_e),
    .out_ready(out_ready), .product(product_e), .busy(busy_e)
  );

  peasant_mult_seq #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_f),
    .multiplicand(multiplicand), .multiplier(multiplier), .out_valid(out_valid_f),
    .out_ready(out_ready), .product(product_f), .busy(busy_f)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Reference latency for early exit: number of significant bits in A, minimum 1.
  function automatic int bit_len(input logic [W-1:0] v);
    int n = 1;
    for (int i = 0; i < W; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  // Entry and exit at #1 after a rising edge; the accepting edge is the one inside this task.
  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv);
    int k = 0;
    while (!(in_ready_e && in_ready_f) && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check("accept_ready", 64'(in_ready_e && in_ready_f), 64'd1);
    multiplier   = av;
    multiplicand = bv;
    in_valid     = 1'b1;
    @(posedge clk); #1;
    in_valid     = 1'b0;
  endtask

  // Runs one product through both instances with out_ready high; optionally pokes in_valid mid-RUN.
  task automatic run_txn(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit poke);
    logic [63:0] exp_p = 64'(av) * 64'(bv);
    int n_e = 0, n_f = 0;
    logic [63:0] p_e = '0, p_f = '0;
    accept(av, bv);
    for (int k = 1; k <= 40; k++) begin
      if (poke && k == 2) begin
        multiplier = ~av; multiplicand = 32'h5A5A_5A5A; in_valid = 1'b1;
      end
      if (poke && k == 3) in_valid = 1'b0;
      @(posedge clk); #1;
      if (n_e == 0 && out_valid_e) begin n_e = k; p_e = product_e; end
      if (n_f == 0 && out_valid_f) begin n_f = k; p_f = product_f; end
    end
    check({tag, "_prod_ee"}, p_e, exp_p);
    check({tag, "_lat_ee"}, 64'(n_e), 64'(bit_len(av)));
    check({tag, "_prod_full"}, p_f, exp_p);
    check({tag, "_lat_full"}, 64'(n_f), 64'(W));
  endtask

  initial begin
    logic [63:0] held;
    int k;

    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready_e), 64'd1);
    check("rst_out_valid", 64'(out_valid_e), 64'd0);
    check("rst_busy", 64'(busy_e), 64'd0);
    check("rst_product", product_e, 64'd0);

    run_txn("5x3", 32'd5, 32'd3, 1'b0);
    run_txn("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_txn("a0", 32'd0, 32'h1234, 1'b0);
    run_txn("b0", 32'h1234, 32'd0, 1'b0);
    run_txn("a1", 32'd1, 32'hDEAD_BEEF, 1'b0);
    run_txn("poke", 32'hF000_0000, 32'd3, 1'b1);
    run_txn("after_poke", 32'd11, 32'd13, 1'b0);

    // Output stall: DONE must hold with a stable product.
    out_ready = 1'b0;
    accept(32'd9, 32'd7);
    k = 0;
    while (!(out_valid_e && out_valid_f) && k < 40) begin
      @(posedge clk); #1; k++;
    end
    check("stall_reach_done", 64'(out_valid_e && out_valid_f), 64'd1);
    held = product_e;
    check("stall_product", held, 64'd63);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 64'(out_valid_e), 64'd1);
      check("stall_hold", product_e, 64'd63);
      check("stall_in_ready", 64'(in_ready_e), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall_release_idle", 64'(in_ready_e), 64'd1);
    check("stall_release_valid", 64'(out_valid_e), 64'd0);
    out_ready = 1'b1;

    // Asynchronous reset in the middle of a long run.
    accept(32'h8000_0000, 32'd77);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy_e), 64'd0);
    check("arst_in_ready", 64'(in_ready_e), 64'd0);
    check("arst_out_valid", 64'(out_valid_e), 64'd0);
    check("arst_product", product_e, 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_release_ready", 64'(in_ready_e), 64'd1);
    run_txn("7x6", 32'd7, 32'd6, 1'b0);

    for (int i = 0; i < 20; i++)
      run_txn("rand", $urandom >> $urandom_range(0, 31), $urandom, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
